rs_encoder_204_188: RTL and testbench

RS_ENCODER_204_188 -- requirements
Module: rs_encoder_204_188

---
 rtl/rs_encoder_204_188.sv | 153 +++++++++++++++
 tb/tb_rs_encoder_204_188.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_encoder_204_188.sv
// Systematic shortened RS(204,188,t=8) encoder over GF(256), poly 0x11D.
// Info bytes pass through one cycle late; 16 parity bytes follow each complete packet.

module rs_encoder_204_188 (
    input  logic       Clk,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_sop,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sop,
    output logic       out_parity,
    output logic       err_abort
);

    // Constant-operand uses reduce to fixed XOR networks.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ ({8{x[7]}} & 8'h1D);
        end
        return p;
    endfunction

    // g(x) = prod (x + alpha^i), i = 0..15; returns g0..g15 (g16 = 1).
    function automatic logic [15:0][7:0] gen_poly();
        logic [16:0][7:0] g;
        logic [16:0][7:0] nxt;
        logic [7:0]       root;
        g    = '0;
        g[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < 16; i++) begin
            nxt    = '0;
            nxt[0] = gf_mul(root, g[0]);
            for (int j = 1; j < 17; j++) begin
                nxt[j] = g[j-1] ^ gf_mul(root, g[j]);
            end
            g    = nxt;
            root = gf_mul(root, 8'h02);
        end
        return g[15:0];
    endfunction

    localparam logic [15:0][7:0] GenPoly = gen_poly();
    localparam logic [7:0]       LastByte = 8'd187;

    typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

    state_e           state_q;
    logic [7:0]       bcnt_q;
    logic [3:0]       pcnt_q;
    logic [15:0][7:0] lfsr_q;
    logic [7:0]       out_data_q;
    logic             out_valid_q;
    logic             out_sop_q;
    logic             out_parity_q;
    logic             err_abort_q;

    logic [7:0]       fb;
    logic [15:0][7:0] lfsr_fold_d;
    logic [15:0][7:0] lfsr_fresh_d;
    logic             accept;

    assign in_ready   = (state_q != StParity);
    assign accept     = in_valid && in_ready;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_sop    = out_sop_q;
    assign out_parity = out_parity_q;
    assign err_abort  = err_abort_q;

    // lfsr_fresh_d is the fold into a cleared register, used for byte 0 of a packet.
    always_comb begin
        lfsr_fold_d     = '0;
        lfsr_fresh_d    = '0;
        fb              = in_data ^ lfsr_q[15];
        lfsr_fold_d[0]  = gf_mul(fb, GenPoly[0]);
        lfsr_fresh_d[0] = gf_mul(in_data, GenPoly[0]);
        for (int i = 1; i < 16; i++) begin
            lfsr_fold_d[i]  = lfsr_q[i-1] ^ gf_mul(fb, GenPoly[i]);
            lfsr_fresh_d[i] = gf_mul(in_data, GenPoly[i]);
        end
    end

    always_ff @(posedge Clk) begin
        if (!start) begin
            state_q      <= StIdle;
            bcnt_q       <= 8'd0;
            pcnt_q       <= 4'd0;
            lfsr_q       <= '0;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            out_sop_q    <= 1'b0;
            out_parity_q <= 1'b0;
            err_abort_q  <= 1'b0;
        end else begin
            out_valid_q  <= 1'b0;
            out_sop_q    <= 1'b0;
            out_parity_q <= 1'b0;
            err_abort_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept && in_sop) begin
                        lfsr_q      <= lfsr_fresh_d;
                        bcnt_q      <= 8'd1;
                        state_q     <= StData;
                        out_data_q  <= in_data;
                        out_valid_q <= 1'b1;
                        out_sop_q   <= 1'b1;
                    end
                end
                StData: begin
                    if (accept) begin
                        out_data_q  <= in_data;
                        out_valid_q <= 1'b1;
                        if (in_sop) begin
                            err_abort_q <= 1'b1;
                            lfsr_q      <= lfsr_fresh_d;
                            bcnt_q      <= 8'd1;
                            out_sop_q   <= 1'b1;
                        end else begin
                            lfsr_q <= lfsr_fold_d;
                            if (bcnt_q == LastByte) begin
                                bcnt_q  <= 8'd0;
                                pcnt_q  <= 4'd0;
                                state_q <= StParity;
                            end else begin
                                bcnt_q <= bcnt_q + 8'd1;
                            end
                        end
                    end
                end
                StParity: begin
                    out_data_q   <= lfsr_q[15];
                    out_valid_q  <= 1'b1;
                    out_parity_q <= 1'b1;
                    lfsr_q       <= {lfsr_q[14:0], 8'h00};
                    pcnt_q       <= pcnt_q + 4'd1;
                    if (pcnt_q == 4'd15) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_encoder_204_188.sv
// Randomised bench for rs_encoder_204_188 against a polynomial-division RS model
// with syndrome evaluation of the observed codewords.

module tb_rs_encoder_204_188;

    logic       Clk;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_sop;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_sop;
    logic       out_parity;
    logic       err_abort;

    rs_encoder_204_188 dut (
        .Clk       (Clk),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_parity(out_parity),
        .err_abort (err_abort)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    int gexp [510];
    int glog [256];
    int gpoly [17];

    logic [7:0] pkt [188];
    logic [7:0] par_ref [16];
    logic [9:0] exp_q [$];
    logic [7:0] obs_cw [$];
    logic [7:0] par_obs [$];
    logic [9:0] exp_word;

    bit mon_en    = 1'b0;
    int run_len   = 0;
    int max_run   = 0;
    int abort_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[glog[a] + glog[b]];
    endfunction

    // Textbook long division of m(x)*x^16 by g(x); codeword byte 0 is degree 203.
    function automatic void calc_parity();
        int poly [204];
        int c;
        for (int k = 0; k < 16; k++) poly[k] = 0;
        for (int k = 0; k < 188; k++) poly[203-k] = int'(pkt[k]);
        for (int deg = 203; deg >= 16; deg--) begin
            c = poly[deg];
            if (c != 0) begin
                for (int j = 0; j < 17; j++) poly[deg-16+j] = poly[deg-16+j] ^ gmul(c, gpoly[j]);
            end
        end
        for (int k = 0; k < 16; k++) par_ref[k] = 8'(poly[15-k]);
    endfunction

    function automatic int syndrome(input int i);
        int s = 0;
        for (int k = 0; k < 204; k++) s = gmul(s, gexp[i]) ^ int'(obs_cw[k]);
        return s;
    endfunction

    always @(negedge Clk) begin
        if (mon_en) begin
            if (err_abort) abort_cnt++;
            if (out_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 32'd1, 32'd0);
                end else begin
                    exp_word = exp_q.pop_front();
                    check_eq("out_word", {22'd0, out_sop, out_parity, out_data}, {22'd0, exp_word});
                end
                if (out_sop) obs_cw.delete();
                obs_cw.push_back(out_data);
                if (out_parity) par_obs.push_back(out_data);
                if (obs_cw.size() == 204 && out_parity) begin
                    for (int i = 0; i < 16; i++) check_eq("syndrome", syndrome(i), 0);
                end
            end else begin
                run_len = 0;
                if (out_sop || out_parity) check_eq("idle_flags", {out_sop, out_parity}, 0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic s);
        int guard = 0;
        while (!in_ready && guard < 64) begin
            @(posedge Clk);
            #1;
            guard++;
        end
        if (guard >= 64) check_eq("ready_timeout", 32'd0, 32'd1);
        in_data  = d;
        in_sop   = s;
        in_valid = 1'b1;
        exp_q.push_back({s, 1'b0, d});
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic send_packet(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge Clk);
                #1;
            end
            send_byte(pkt[k], k == 0);
        end
        if (n == 188) begin
            calc_parity();
            for (int k = 0; k < 16; k++) exp_q.push_back({2'b01, par_ref[k]});
        end
    endtask

    task automatic rand_pkt();
        for (int k = 0; k < 188; k++) pkt[k] = 8'($urandom);
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while (exp_q.size() > 0 && cyc < 1000) begin
            @(posedge Clk);
            #1;
            cyc++;
        end
        check_eq("drain", exp_q.size(), 0);
        repeat (3) @(posedge Clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x = 1;
        for (int k = 0; k < 255; k++) begin
            gexp[k]     = x;
            gexp[k+255] = x;
            glog[x]     = k;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 285;
        end
        glog[0] = 0;
        for (int j = 0; j < 17; j++) gpoly[j] = 0;
        gpoly[0] = 1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 16; j >= 1; j--) gpoly[j] = gpoly[j-1] ^ gmul(gpoly[j], gexp[i]);
            gpoly[0] = gmul(gpoly[0], gexp[i]);
        end

        start = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("rst_out_data", out_data, 8'h00);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_sop", out_sop, 0);
        check_eq("rst_out_parity", out_parity, 0);
        check_eq("rst_err_abort", err_abort, 0);
        start  = 1'b1;
        mon_en = 1'b1;
        check_eq("rst_in_ready", in_ready, 1);

        // Non-sop bytes in IDLE must be swallowed without output.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_sop = 1'b0; in_data = 8'($urandom);
            @(posedge Clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("idle_ignore_ready", in_ready, 1);
        check_eq("idle_ignore_valid", out_valid, 0);

        for (int k = 0; k < 188; k++) pkt[k] = 8'h00;
        max_run = 0;
        send_packet(188, 1'b0);
        wait_drain();
        check_eq("zero_gapless_len", max_run, 204);

        pkt[187] = 8'h01;
        par_obs.delete();
        send_packet(188, 1'b0);
        wait_drain();
        check_eq("impulse_par_cnt", par_obs.size(), 16);
        if (par_obs.size() == 16) begin
            for (int k = 0; k < 16; k++) check_eq("impulse_par", par_obs[k], gpoly[15-k]);
        end

        for (int p = 0; p < 4; p++) begin
            rand_pkt();
            send_packet(188, 1'b1);
        end
        wait_drain();

        abort_cnt = 0;
        rand_pkt();
        send_packet(100, 1'b1);
        rand_pkt();
        send_packet(188, 1'b1);
        wait_drain();
        check_eq("abort_pulse_cnt", abort_cnt, 1);

        abort_cnt = 0;
        rand_pkt();
        send_packet(188, 1'b0);
        repeat (6) @(posedge Clk);
        #1;
        start = 1'b0;
        @(posedge Clk);
        #1;
        start = 1'b1;
        exp_q.delete();
        check_eq("rst_parity_valid", out_valid, 0);
        check_eq("rst_parity_ready", in_ready, 1);
        repeat (3) @(posedge Clk);
        #1;
        check_eq("rst_parity_quiet", out_valid, 0);
        rand_pkt();
        send_packet(188, 1'b1);
        wait_drain();
        check_eq("rst_parity_no_abort", abort_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
